// File: rtl/bf16_fma_arbiter.sv
// Round-robin front end for one shared bf16 multiply-add datapath.
// A winning operand triple is held on the datapath for LAT cycles, then the result is returned with the requester id.
module bf16_fma_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  input  logic [16*NREQ-1:0] req_c,
  output logic [NREQ-1:0]    req_ready,
  output logic [15:0]        fma_a,
  output logic [15:0]        fma_b,
  output logic [15:0]        fma_c,
  input  logic [15:0]        fma_res,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [15:0]        rsp_data,
  input  logic               rsp_ready,
  output logic               busy
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_r;
  logic [IDW-1:0] rr_ptr_r;
  logic [IDW-1:0] id_r;
  logic [CW-1:0]  cnt_r;
  logic [IDW-1:0] grant_s;
  logic           found_s;
  logic [15:0]    sel_a_s;
  logic [15:0]    sel_b_s;
  logic [15:0]    sel_c_s;
  logic [IDW-1:0] next_ptr_s;

  // Round-robin search: indices at or above rr_ptr first, then wrap to the ones below it
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req_valid[i] && (IDW'(i) >= rr_ptr_r)) begin
        found_s = 1'b1;
        grant_s = IDW'(i);
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req_valid[i] && (IDW'(i) < rr_ptr_r)) begin
        found_s = 1'b1;
        grant_s = IDW'(i);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Operand mux for the granted slice and the one-hot accept strobe
  always_comb begin
    sel_a_s   = 16'h0000;
    sel_b_s   = 16'h0000;
    sel_c_s   = 16'h0000;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s == IDW'(i)) begin
        sel_a_s      = req_a[16*i +: 16];
        sel_b_s      = req_b[16*i +: 16];
        sel_c_s      = req_c[16*i +: 16];
        req_ready[i] = (state_r == IDLE) && found_s;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Served requester drops to lowest priority; wraps explicitly for non-power-of-2 NREQ
  always_comb begin
    if (id_r == IDW'(NREQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = id_r + IDW'(1);
    end
  end

  // Sequencer: accept, hold operands for LAT cycles, capture, then wait for the consumer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      rr_ptr_r  <= '0;
      id_r      <= '0;
      cnt_r     <= '0;
      fma_a     <= 16'h0000;
      fma_b     <= 16'h0000;
      fma_c     <= 16'h0000;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= 16'h0000;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            fma_a   <= sel_a_s;
            fma_b   <= sel_b_s;
            fma_c   <= sel_c_s;
            id_r    <= grant_s;
            cnt_r   <= CW'(LAT - 1);
            busy    <= 1'b1;
            state_r <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            rsp_data  <= fma_res;
            rsp_id    <= id_r;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr_r  <= next_ptr_s;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_fma_arbiter.sv
// Directed bench for bf16_fma_arbiter with a table-driven stand-in for the bf16 multiply-add datapath.
module tb_bf16_fma_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_a, req_b, req_c;
  logic [3:0]  req_ready;
  logic [15:0] fma_a, fma_b, fma_c, fma_res;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_ready;
  logic        busy;

  logic [15:0] ta [4] = '{16'h3F80, 16'h4040, 16'h4000, 16'h4080};
  logic [15:0] tb [4] = '{16'h4000, 16'h4000, 16'h4040, 16'h4000};
  logic [15:0] tc [4] = '{16'h4040, 16'h3F80, 16'h4000, 16'h3F80};
  logic [15:0] tr [4] = '{16'h40A0, 16'h40E0, 16'h4100, 16'h4110};

  int acc_id_q[$], acc_cyc_q[$], rid_q[$], rdata_q[$], rcyc_q[$];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int ab, rb, ok;

  bf16_fma_arbiter #(.NREQ(4), .LAT(2), .IDW(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_c(req_c), .req_ready(req_ready), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_res(fma_res), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Hand-computed bf16 results for the operand triples the bench uses
  always_comb begin
    case ({fma_a, fma_b, fma_c})
      48'h3F80_4000_4040: fma_res = 16'h40A0;
      48'h4040_4000_3F80: fma_res = 16'h40E0;
      48'h4000_4040_4000: fma_res = 16'h4100;
      48'h4080_4000_3F80: fma_res = 16'h4110;
      48'hC000_4000_4040: fma_res = 16'hBF80;
      default:            fma_res = 16'h7FC0;
    endcase
  end

  // Log accept and response handshakes with their cycle numbers
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (|(req_valid & req_ready)) begin
        for (int i = 0; i < 4; i++) begin
          if (req_ready[i]) begin
            acc_id_q.push_back(i);
            acc_cyc_q.push_back(cyc);
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        rid_q.push_back(int'(rsp_id));
        rdata_q.push_back(int'(rsp_data));
        rcyc_q.push_back(cyc);
      end
    end
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_acc(input int n, input string tag);
    for (int k = 0; k < 100 && acc_id_q.size() < n; k++) @(negedge clk);
    check(tag, 32'(acc_id_q.size() >= n), 32'd1);
  endtask

  task automatic wait_rsp(input int n, input string tag);
    for (int k = 0; k < 100 && rid_q.size() < n; k++) @(negedge clk);
    check(tag, 32'(rid_q.size() >= n), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = ta[i];
      req_b[16*i +: 16] = tb[i];
      req_c[16*i +: 16] = tc[i];
    end
    pulse_reset();

    // Reset state and a single request from requester 0
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_fma", {fma_a, fma_b ^ fma_c}, 32'd0);
    ab = acc_id_q.size(); rb = rid_q.size();
    req_valid = 4'b0001;
    #1 check("single_ready", 32'(req_ready), 32'h1);
    wait_acc(ab + 1, "single_acc");
    req_valid = 4'b0000;
    wait_rsp(rb + 1, "single_rsp");
    check("single_id", 32'(rid_q[rb]), 32'd0);
    check("single_data", 32'(rdata_q[rb]), 32'h40A0);
    check("single_lat", 32'(rcyc_q[rb] - acc_cyc_q[ab]), 32'd3);
    repeat (6) @(negedge clk);
    check("single_once", 32'(acc_id_q.size() - ab), 32'd1);

    // Round-robin with all requesters continuously valid
    pulse_reset();
    ab = acc_id_q.size(); rb = rid_q.size();
    req_valid = 4'b1111;
    wait_rsp(rb + 5, "rr_rsp");
    req_valid = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      check("rr_id", 32'(rid_q[rb + k]), 32'(k % 4));
      check("rr_data", 32'(rdata_q[rb + k]), 32'(tr[k % 4]));
    end
    for (int k = 1; k < 5; k++)
      check("rr_spacing", 32'(acc_cyc_q[ab + k] - acc_cyc_q[ab + k - 1]), 32'd4);

    // Back-pressure: hold the response for 10 cycles
    pulse_reset();
    ab = acc_id_q.size(); rb = rid_q.size();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    wait_acc(ab + 1, "bp_acc");
    req_valid = 4'b0000;
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    req_valid = 4'b0100;
    ok = 1;
    repeat (10) begin
      if (!(rsp_valid && rsp_data == 16'h40E0 && rsp_id == 3'd1 && req_ready == 4'b0000 && busy))
        ok = 0;
      @(negedge clk);
    end
    check("bp_hold", 32'(ok), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_idle", {28'd0, busy, rsp_valid, 2'b00}, 32'd0);
    check("bp_ready", 32'(req_ready), 32'h4);
    wait_acc(ab + 2, "bp_acc2");
    req_valid = 4'b0000;
    check("bp_next_acc", 32'(acc_cyc_q[ab + 1] - rcyc_q[rb]), 32'd1);
    wait_rsp(rb + 2, "bp_rsp2");
    check("bp_data2", 32'(rdata_q[rb + 1]), 32'h4100);

    // Priority rotation: after serving 1, requesters 0 and 3 compete
    pulse_reset();
    ab = acc_id_q.size(); rb = rid_q.size();
    req_valid = 4'b0010;
    wait_acc(ab + 1, "prio_acc1");
    req_valid = 4'b1001;
    wait_acc(ab + 2, "prio_acc2");
    req_valid[acc_id_q[ab + 1]] = 1'b0;
    wait_acc(ab + 3, "prio_acc3");
    req_valid = 4'b0000;
    check("prio_first", 32'(acc_id_q[ab + 1]), 32'd3);
    check("prio_second", 32'(acc_id_q[ab + 2]), 32'd0);
    wait_rsp(rb + 3, "prio_rsp");
    check("prio_data3", 32'(rdata_q[rb + 1]), 32'h4110);

    // Reset while an operation is in EXEC
    pulse_reset();
    ab = acc_id_q.size(); rb = rid_q.size();
    req_valid = 4'b0100;
    wait_acc(ab + 1, "mid_acc_pre");
    req_valid = 4'b0000;
    wait_rsp(rb + 1, "mid_rsp_pre");
    req_valid = 4'b0001;
    wait_acc(ab + 2, "mid_acc");
    req_valid = 4'b0000;
    check("mid_in_exec", 32'(busy), 32'd1);
    pulse_reset();
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_fma", {fma_a, fma_b | fma_c}, 32'd0);
    repeat (8) @(negedge clk);
    check("mid_no_rsp", 32'(rid_q.size() - rb), 32'd1);
    req_valid = 4'b1010;
    wait_acc(ab + 3, "mid_acc2");
    req_valid = 4'b0000;
    check("mid_grant", 32'(acc_id_q[ab + 2]), 32'd1);
    wait_rsp(rb + 2, "mid_rsp2");
    check("mid_id", 32'(rid_q[rb + 1]), 32'd1);
    check("mid_data", 32'(rdata_q[rb + 1]), 32'h40E0);

    // Operand stability after acceptance
    pulse_reset();
    ab = acc_id_q.size(); rb = rid_q.size();
    req_valid = 4'b0001;
    wait_acc(ab + 1, "stab_acc");
    req_valid = 4'b0000;
    req_a[15:0] = 16'hC000;
    check("stab_fma_a0", 32'(fma_a), 32'h3F80);
    @(negedge clk);
    check("stab_fma_a1", 32'(fma_a), 32'h3F80);
    wait_rsp(rb + 1, "stab_rsp");
    check("stab_data", 32'(rdata_q[rb]), 32'h40A0);
    req_a[15:0] = ta[0];

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bf16_fma_arbiter.md
Name: bf16_fma_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational bfloat16 multiply-add datapath (multiplier feeding the adder) between NREQ requesters.
- Each requester submits an operand triple (a, b, c) over a valid/ready handshake. The block latches the triple and drives the shared datapath for LAT cycles.
- It captures fma = a*b + c and returns it with the requester ID over a valid/ready response channel.
- Sits between the compute clients and the bf16 multiply/add pair. One operation is in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 2, cycles the operands are held stable on the datapath before the result is sampled (>=1); covers the mul+add combinational depth.
- IDW, 3, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  16*NREQ  bf16 multiplicand; requester i occupies bits [16i+15:16i].
- req_b  in  16*NREQ  bf16 multiplier, same packing as req_a.
- req_c  in  16*NREQ  bf16 addend, same packing as req_a.
- req_ready  out  NREQ  one-hot grant/accept strobe.
- fma_a  out  16  operand a to the shared multiplier.
- fma_b  out  16  operand b to the shared multiplier.
- fma_c  out  16  addend c to the shared adder.
- fma_res  in  16  bf16 result from the shared adder.
- rsp_valid  out  1  response valid.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- rsp_data  out  16  captured bf16 result.
- rsp_ready  in  1  response consumer ready.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, rr_ptr=0, cnt=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, fma_a/b/c=0, busy=0.
  - Applies from any state. An in-flight operation is discarded with no response, and a pending rsp_valid drops on the next cycle.
- States: IDLE, EXEC, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[grant]=1 combinationally; all other req_ready bits are 0. req_ready is 0 outside IDLE.
  - A handshake occurs in the cycle where req_valid[grant] & req_ready[grant] are both 1. On that edge the block latches op_a/b/c from slice grant, latches id=grant, sets cnt=LAT-1, and moves to EXEC.
  - With no valid request, the block stays in IDLE. fma_a/b/c hold their last values and are not cleared.
- EXEC:
  - fma_a/b/c = latched operands, held stable every cycle.
  - If cnt!=0, decrement cnt.
  - If cnt==0, rsp_data<=fma_res, rsp_id<=id, rsp_valid<=1, and move to RESP.
- RESP:
  - rsp_valid=1, and rsp_data/rsp_id are held stable until rsp_valid & rsp_ready.
  - On the handshake: rsp_valid<=0, rr_ptr<=(id+1) mod NREQ, and move to IDLE.
  - A new request cannot be accepted in the same cycle as the response handshake; the earliest accept is the following cycle.
- Latency: accept at edge T, so EXEC runs cycles T+1..T+LAT, result sampled at edge T+LAT, and rsp_valid is high from cycle T+LAT+1.
  - Minimum issue interval is LAT+2 cycles with rsp_ready tied high.
- Fairness: the requester just served has the lowest priority next. With all requesters continuously valid, grants rotate 0,1,2,...,NREQ-1,0.
- Requesters must hold req_valid and operands until their req_ready; changes after acceptance are ignored.
- Width rule: rr_ptr wraps from NREQ-1 to 0 (non-power-of-2 NREQ included).
- No arithmetic is performed in this block. Exponent overflow, sign and special-value handling belong to the datapath; fma_res is passed through unmodified.

Test Plan:
- Single request:
  - Stimulus: requester 0 sends a=0x3F80 (1.0), b=0x4000 (2.0), c=0x4040 (3.0), with the datapath attached and LAT=2.
  - Required: req_ready[0] pulses once; rsp_valid rises 3 cycles after accept with rsp_id=0 and rsp_data=0x40A0 (5.0).
- Round-robin:
  - Stimulus: all 4 requesters valid continuously, rsp_ready=1.
  - Required: rsp_id sequence 0,1,2,3,0 and accepts spaced exactly LAT+2=4 cycles apart.
- Back-pressure:
  - Stimulus: rsp_ready=0 for 10 cycles after rsp_valid rises.
  - Required: rsp_data/rsp_id stable, req_ready all 0 and busy=1 throughout; after rsp_ready goes high, IDLE on the next cycle and the next accept one cycle later.
- Priority rotation:
  - Stimulus: rr_ptr=2 (after serving id 1), with requesters 0 and 3 valid.
  - Required: 3 is granted first, then 0.
- Reset mid-EXEC:
  - Stimulus: rst_n=0 for one edge while in EXEC.
  - Required: next cycle busy=0, rsp_valid=0, fma_a/b/c=0, and no response is ever issued for that request; a subsequent request from id 1 is served normally with rr_ptr starting at 0.
- Operand stability:
  - Stimulus: requester changes req_a to 0xC000 the cycle after accept.
  - Required: fma_a keeps the accepted value through EXEC and the result reflects the original operands.
